// File: rtl/nios_mult_pipe_cell_if.sv
// -----------------------------------------------------------------------------
// nios_mult_pipe_cell_if
//   Request/response bundle for the pipelined multiplier cell.
//   master : issuing side (CPU E-stage or accelerator). It drives the request
//            and out_ready, and samples in_ready and the result.
//   slave  : the multiplier cell itself.
// Signals
//   in_valid/in_ready   request handshake
//   in_op               00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_a, in_b          operands (DATA_W)
//   in_tag              opaque tag (TAG_W), echoed on out_tag
//   out_valid/out_ready result handshake
//   out_result          selected product half (DATA_W)
//   out_tag             tag of the returned operation
// -----------------------------------------------------------------------------
interface nios_mult_pipe_cell_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/nios_mult_pipe_cell.sv
// -----------------------------------------------------------------------------
// nios_mult_pipe_cell
//   Three-stage handshaked DATA_W x DATA_W multiplier. It returns the low half
//   (MUL) or the high half (MULH / MULHSU / MULHU) of the 2*DATA_W product.
//     S1: unsigned LANE_W x LANE_W lane products, plus op, tag, operands and sign flags
//     S2: shifted sum of the lane products (unsigned product P_u)
//     S3: signed correction and half selection, which forms the output register
//   All stages advance together when S3 is empty or being drained. There is
//   no bubble collapsing, so the latency is a fixed 3 cycles.
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   flush    synchronous kill of every in-flight operation
//   bus      nios_mult_pipe_cell_if.slave request/result bundle
//   in_acc   (MULT_CELL_ACCUM_EN only) accumulate this op into acc
//   acc_clr  (MULT_CELL_ACCUM_EN only) synchronous accumulator clear
// Build option
//   MULT_CELL_ACCUM_EN adds a 2*DATA_W accumulator and the in_acc/acc_clr ports.
// -----------------------------------------------------------------------------
module nios_mult_pipe_cell #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 16,
    parameter int TAG_W  = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
`ifdef MULT_CELL_ACCUM_EN
    input  logic in_acc,
    input  logic acc_clr,
`endif
    nios_mult_pipe_cell_if.slave bus
);

    localparam int N   = DATA_W / LANE_W;
    localparam int NPP = N * N;
    localparam int PW  = 2 * LANE_W;
    localparam int RW  = 2 * DATA_W;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    logic adv;

    // stage 1
    logic              s1_valid;
    logic [PW-1:0]     s1_pp [NPP];
    logic [1:0]        s1_op;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic              s1_a_s;
    logic              s1_b_s;
    logic              s1_acc;

    // stage 2
    logic              s2_valid;
    logic [RW-1:0]     s2_pu;
    logic [1:0]        s2_op;
    logic [TAG_W-1:0]  s2_tag;
    logic [DATA_W-1:0] s2_a;
    logic [DATA_W-1:0] s2_b;
    logic              s2_a_s;
    logic              s2_b_s;
    logic              s2_acc;

    // stage 3 (output register)
    logic              s3_valid;
    logic [DATA_W-1:0] s3_result;
    logic [TAG_W-1:0]  s3_tag;

    logic [PW-1:0]     pp_next [NPP];
    logic              a_s_next;
    logic              b_s_next;
    logic              acc_next;
    logic [RW-1:0]     pu_sum;
    logic [RW-1:0]     p_corr;
    logic [RW-1:0]     p_sel;
    logic [DATA_W-1:0] result_next;

    // Stall only when the output is full and not being drained. While flush
    // is high, adv may still be 1, but the valid update below takes priority.
    assign adv          = ~s3_valid | bus.out_ready;
    assign bus.in_ready = adv;

    assign bus.out_valid  = s3_valid;
    assign bus.out_result = s3_result;
    assign bus.out_tag    = s3_tag;

`ifdef MULT_CELL_ACCUM_EN
    assign acc_next = in_acc;
`else
    assign acc_next = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pp_next[i*N+j] = PW'(bus.in_a[i*LANE_W +: LANE_W]) *
                                 PW'(bus.in_b[j*LANE_W +: LANE_W]);
            end
        end
    end

    // Unsigned-product correction flags. MUL needs none because the low half
    // is the same for signed and unsigned operands.
    assign a_s_next = bus.in_a[DATA_W-1] & ((bus.in_op == OP_MULH) | (bus.in_op == OP_MULHSU));
    assign b_s_next = bus.in_b[DATA_W-1] &  (bus.in_op == OP_MULH);

    // Lane product a[i]*b[j] carries weight 2^((i+j)*LANE_W).
    always_comb begin
        pu_sum = '0;
        for (int k = 0; k < NPP; k++) begin
            pu_sum = pu_sum + (RW'(s1_pp[k]) << (((k / N) + (k % N)) * LANE_W));
        end
    end

    // Two's-complement reinterpretation of a sign bit subtracts the other
    // operand shifted into the high half (mod 2^RW).
    always_comb begin
        p_corr = s2_pu;
        if (s2_a_s) p_corr = p_corr - (RW'(s2_b) << DATA_W);
        if (s2_b_s) p_corr = p_corr - (RW'(s2_a) << DATA_W);
    end

`ifdef MULT_CELL_ACCUM_EN
    logic [RW-1:0] acc;
    logic [RW-1:0] acc_base;
    logic          acc_load;

    // Clear takes effect before a coincident accumulate.
    assign acc_base = acc_clr ? '0 : acc;
    assign acc_load = adv & s2_valid & ~flush & s2_acc;
    assign p_sel    = s2_acc ? (acc_base + p_corr) : p_corr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (acc_load) begin
            acc <= acc_base + p_corr;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end
`else
    assign p_sel = p_corr;
    logic unused_acc;
    assign unused_acc = s2_acc;
`endif

    assign result_next = (s2_op == OP_MUL) ? p_sel[DATA_W-1:0] : p_sel[RW-1:DATA_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NPP; k++) s1_pp[k] <= '0;
            s1_op     <= '0;
            s1_tag    <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_a_s    <= 1'b0;
            s1_b_s    <= 1'b0;
            s1_acc    <= 1'b0;
            s2_pu     <= '0;
            s2_op     <= '0;
            s2_tag    <= '0;
            s2_a      <= '0;
            s2_b      <= '0;
            s2_a_s    <= 1'b0;
            s2_b_s    <= 1'b0;
            s2_acc    <= 1'b0;
            s3_result <= '0;
            s3_tag    <= '0;
        end else if (adv) begin
            for (int k = 0; k < NPP; k++) s1_pp[k] <= pp_next[k];
            s1_op     <= bus.in_op;
            s1_tag    <= bus.in_tag;
            s1_a      <= bus.in_a;
            s1_b      <= bus.in_b;
            s1_a_s    <= a_s_next;
            s1_b_s    <= b_s_next;
            s1_acc    <= acc_next;
            s2_pu     <= pu_sum;
            s2_op     <= s1_op;
            s2_tag    <= s1_tag;
            s2_a      <= s1_a;
            s2_b      <= s1_b;
            s2_a_s    <= s1_a_s;
            s2_b_s    <= s1_b_s;
            s2_acc    <= s1_acc;
            s3_result <= result_next;
            s3_tag    <= s2_tag;
        end
    end

endmodule

// File: tb/tb_nios_mult_pipe_cell.sv
module tb_nios_mult_pipe_cell;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
`ifdef MULT_CELL_ACCUM_EN
    logic in_acc = 1'b0;
    logic acc_clr = 1'b0;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    nios_mult_pipe_cell_if #(.DATA_W(32), .TAG_W(5)) bus ();

    nios_mult_pipe_cell #(.DATA_W(32), .LANE_W(16), .TAG_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
`ifdef MULT_CELL_ACCUM_EN
        .in_acc  (in_acc),
        .acc_clr (acc_clr),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
    endtask

    task automatic test_reset();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
        bus.out_ready = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        tests_run++;
        if (bus.out_result !== 32'h0) begin tests_failed++; $display("FAIL reset_out_result got %h want 0", bus.out_result); end
        tests_run++;
        if (bus.out_tag !== 5'h0) begin tests_failed++; $display("FAIL reset_out_tag got %h want 0", bus.out_tag); end
        step();
    endtask

    task automatic test_mul_latency();
        drive(1'b1, 2'b00, 32'h0001_2345, 32'h0000_1000, 5'h15);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_c1_valid got %b want 0", bus.out_valid); end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_c2_valid got %b want 0", bus.out_valid); end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL lat_c3_valid got %b want 1", bus.out_valid); end
        tests_run++;
        if (bus.out_result !== 32'h1234_5000) begin tests_failed++; $display("FAIL lat_result got %h want 12345000", bus.out_result); end
        tests_run++;
        if (bus.out_tag !== 5'h15) begin tests_failed++; $display("FAIL lat_tag got %h want 15", bus.out_tag); end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_drain_valid got %b want 0", bus.out_valid); end
    endtask

    // MULH, MULHU, MULHSU on a=-1, b=0x8000_0000, issued back to back
    task automatic test_signed_ops();
        logic [1:0]  ops [3];
        logic [31:0] exp [3];
        ops = '{2'b01, 2'b11, 2'b10};
        exp = '{32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, ops[i], 32'hFFFF_FFFF, 32'h8000_0000, 5'(i + 1));
            else       drive(1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
            step();
            if (i >= 2) begin
                tests_run++;
                if (bus.out_valid !== 1'b1 || bus.out_result !== exp[i-2] || bus.out_tag !== 5'(i - 1)) begin
                    tests_failed++;
                    $display("FAIL signed_op%0d got v=%b r=%h t=%h want v=1 r=%h t=%h",
                             i - 2, bus.out_valid, bus.out_result, bus.out_tag, exp[i-2], 5'(i - 1));
                end
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops [8];
        logic [31:0] av  [8];
        logic [31:0] bv  [8];
        logic [31:0] exp [8];
        ops = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b00};
        av  = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'h0001_0000, 32'h0001_0000, 32'h8000_0000, 32'h1234_5678};
        bv  = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'h0001_0000, 32'h0001_0000, 32'h8000_0000, 32'h0000_0010};
        exp = '{32'h0000_000F, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF,
                32'h0000_0000, 32'h0000_0001, 32'h4000_0000, 32'h2345_6780};
        for (int i = 0; i < 11; i++) begin
            if (i < 8) drive(1'b1, ops[i], av[i], bv[i], 5'(i + 8));
            else       drive(1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
            step();
            if (i >= 2 && i < 10) begin
                tests_run++;
                if (bus.out_valid !== 1'b1 || bus.out_result !== exp[i-2] || bus.out_tag !== 5'(i + 6)) begin
                    tests_failed++;
                    $display("FAIL b2b_op%0d got v=%b r=%h t=%h want v=1 r=%h t=%h",
                             i - 2, bus.out_valid, bus.out_result, bus.out_tag, exp[i-2], 5'(i + 6));
                end
            end else if (i == 10) begin
                tests_run++;
                if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [3];
        exp = '{32'd42, 32'd10000, 32'd1};
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'd7, 32'd6, 5'd1);
        step();
        drive(1'b1, 2'b00, 32'd100, 32'd100, 5'd2);
        step();
        drive(1'b1, 2'b11, 32'hFFFF_FFFF, 32'd2, 5'd3);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== exp[0] || bus.out_tag !== 5'd1) begin
                tests_failed++;
                $display("FAIL hold_c%0d got rdy=%b v=%b r=%h t=%h want rdy=0 v=1 r=%h t=1",
                         c, bus.in_ready, bus.out_valid, bus.out_result, bus.out_tag, exp[0]);
            end
            step();
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            tests_run++;
            if (k < 3) begin
                if (bus.out_valid !== 1'b1 || bus.out_result !== exp[k] || bus.out_tag !== 5'(k + 1)) begin
                    tests_failed++;
                    $display("FAIL release_op%0d got v=%b r=%h t=%h want v=1 r=%h t=%h",
                             k, bus.out_valid, bus.out_result, bus.out_tag, exp[k], 5'(k + 1));
                end
            end else if (bus.out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL release_drain got v=%b want 0", bus.out_valid);
            end
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b1;
        drive(1'b1, 2'b00, 32'd2, 32'd2, 5'd1);
        step();
        drive(1'b1, 2'b00, 32'd3, 32'd3, 5'd2);
        step();
        drive(1'b1, 2'b00, 32'd4, 32'd4, 5'd3);
        step();
        drive(1'b1, 2'b00, 32'd5, 32'd5, 5'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_c%0d got v=%b want 0", c, bus.out_valid); end
            step();
        end
        drive(1'b1, 2'b00, 32'd9, 32'd9, 5'd9);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
        step();
        step();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd81 || bus.out_tag !== 5'd9) begin
            tests_failed++;
            $display("FAIL post_flush got v=%b r=%h t=%h want v=1 r=51 t=9", bus.out_valid, bus.out_result, bus.out_tag);
        end
        step();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b1;
        drive(1'b1, 2'b00, 32'h0000_1234, 32'h0000_0002, 5'd4);
        step();
        drive(1'b1, 2'b00, 32'd3, 32'd3, 5'd5);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
        step();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h0000_2468) begin
            tests_failed++;
            $display("FAIL prereset got v=%b r=%h want v=1 r=2468", bus.out_valid, bus.out_result);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0 || bus.out_tag !== 5'h0) begin
            tests_failed++;
            $display("FAIL async_reset got v=%b r=%h t=%h want all 0", bus.out_valid, bus.out_result, bus.out_tag);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            tests_run++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL post_reset_c%0d got v=%b rdy=%b want v=0 rdy=1", c, bus.out_valid, bus.in_ready);
            end
        end
    endtask

`ifdef MULT_CELL_ACCUM_EN
    task automatic test_accum();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin drive(1'b1, 2'b00, 32'd2, 32'd3, 5'(i)); in_acc = 1'b1; end
            else       begin drive(1'b0, 2'b00, 32'h0, 32'h0, 5'h0); in_acc = 1'b0; end
            step();
            if (i >= 2) begin
                tests_run++;
                if (bus.out_valid !== 1'b1 || bus.out_result !== 32'((i - 1) * 6)) begin
                    tests_failed++;
                    $display("FAIL accum_op%0d got v=%b r=%h want v=1 r=%h", i - 2, bus.out_valid, bus.out_result, 32'((i - 1) * 6));
                end
            end
        end
        step();
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        drive(1'b1, 2'b00, 32'd4, 32'd5, 5'd7);
        in_acc = 1'b1;
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'h0);
        in_acc = 1'b0;
        step();
        step();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd20) begin
            tests_failed++;
            $display("FAIL accum_after_clr got v=%b r=%h want v=1 r=14", bus.out_valid, bus.out_result);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_mul_latency();
        test_signed_ops();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef MULT_CELL_ACCUM_EN
        test_accum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
